// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: word RAM behind a request/response handshake with fixed access latency.
// Optional store-protected region enabled by defining SECURE_REGION_EN.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | latency countdown; access performed when counter reaches 0
//   RESP  | response held until rsp_ready
module data_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] LOCK_BASE = 32'h0000_0000,
    parameter int unsigned LOCK_SIZE = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [31:0]       rd_word;
    logic              misaligned;
    logic              out_of_range;
    logic              locked;
    logic              acc_err;
    logic              access;
    logic              mem_we;

    assign idx          = addr_q[AW+1:2];
    assign rd_word      = mem[idx];
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = (addr_q[31:AW+2] != '0);

`ifdef SECURE_REGION_EN
    localparam logic [32:0] LOCK_LO = {1'b0, LOCK_BASE};
    localparam logic [32:0] LOCK_HI = {1'b0, LOCK_BASE} + 33'(LOCK_SIZE);
    assign locked = we_q && ({1'b0, addr_q} >= LOCK_LO) && ({1'b0, addr_q} < LOCK_HI);
`else
    assign locked = 1'b0;
`endif

    assign acc_err = misaligned | out_of_range | locked;

    // Gated by reset so nothing looks acceptable while reset is asserted.
    assign req_ready = reset && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        access      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (!we_q && !acc_err) ? rd_word : 32'h0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A reset edge that coincides with the access edge suppresses the write.
    assign mem_we = access && reset && we_q && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table driven through a response scoreboard,
// plus hand sequences for reset, backpressure and mid-operation reset.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;
`ifdef SECURE_REGION_EN
    localparam bit SEC = 1'b1;
`else
    localparam bit SEC = 1'b0;
`endif
    // Keeps general vectors clear of the protected region when it is enabled.
    localparam logic [31:0] OFF = SEC ? 32'h100 : 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    typedef struct {
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        chk_rd;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[18];
    int   nv;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .LOCK_BASE(32'h0000_0000),
        .LOCK_SIZE(256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Issues one request, checks latency, optionally holds the response for `hold`
    // cycles while a competing request is offered, then completes the handshake.
    task automatic run_req(input vec_t v, input int hold);
        int          n;
        logic [31:0] held;
        sb_t         e;
        @(negedge clk);
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(n < 50), 32'd1);
        @(posedge clk);
        e.exp_rdata = v.exp_rdata;
        e.exp_err   = v.exp_err;
        e.chk_rd    = v.chk_rd;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_in_wait", 32'(busy), 32'd1);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n - 1), 32'(LATENCY));
        held = rsp_rdata;
        if (hold > 0) begin
            req_we    = 1'b0;
            req_addr  = 32'h4 + OFF;
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_rsp_rdata", rsp_rdata, held);
                chk("bp_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("rsp_err", 32'(rsp_err), 32'(e.exp_err));
            if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.exp_rdata);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rsp_rdata", rsp_rdata, 32'h0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        nv = 0;
        vecs[nv++] = '{1'b1, 32'h10 + OFF, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'h10 + OFF, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'h10 + OFF, 32'h11223344, 4'h5, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'h10 + OFF, 32'h0,        4'hF, 32'hDE22BE44, 1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'h10 + OFF, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'h10 + OFF, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'h12 + OFF, 32'h0,        4'hF, 32'h0,        1'b1, 1'b1};
        vecs[nv++] = '{1'b1, 32'h0 + OFF,  32'h12345678, 4'hF, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'h1000,     32'hAAAAAAAA, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[nv++] = '{1'b0, 32'h0 + OFF,  32'h0,        4'h0, 32'h12345678, 1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'h13 + OFF, 32'h99999999, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[nv++] = '{1'b0, 32'h10 + OFF, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'hFFC,      32'h0,        4'h0, 32'h0BADF00D, 1'b0, 1'b1};
        vecs[nv++] = '{1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1, 1'b1};
        vecs[nv++] = '{1'b1, 32'h20 + OFF, 32'h55667788, 4'hF, 32'h0,        1'b0, 1'b1};
        vecs[nv++] = '{1'b1, 32'h40,       32'hCAFEF00D, 4'hF, 32'h0,        SEC,  1'b1};
        vecs[nv++] = '{1'b0, 32'h40,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0, !SEC};

        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_be    = 4'hF;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_err",   32'(rsp_err),   32'd0);
            chk("rst_rsp_rdata", rsp_rdata,      32'h0);
            chk("rst_busy",      32'(busy),      32'd0);
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy",      32'(busy),      32'd0);

        for (int i = 0; i < nv; i++) begin
            v = vecs[i];
            run_req(v, 0);
        end

        // Backpressure: response held 5 cycles with a competing request offered.
        v = '{1'b0, 32'h10 + OFF, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1};
        run_req(v, 5);

        // Reset pulse during WAIT of a store: write must not happen.
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'h20 + OFF;
        req_wdata = 32'hFFFFFFFF;
        req_be    = 4'hF;
        req_valid = 1'b1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_busy_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        v = '{1'b0, 32'h20 + OFF, 32'h0, 4'h0, 32'h55667788, 1'b0, 1'b1};
        run_req(v, 0);

        // rsp_ready outside RESP must be ignored; next load still completes normally.
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stray_rsp_ready_idle", 32'(busy), 32'd0);
        v = '{1'b0, 32'h0 + OFF, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1};
        run_req(v, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
